msi_gen: RTL and testbench
==========================

Name: msi_gen

Overview:
- Lightweight MSI initiator for wired peripherals. Converts rising edges on wired interrupt lines into 32-bit MSI writes to an IMSIC interrupt file (seteipnum_le).
- Sits between device interrupt wires and the system bus. It is the initiator counterpart of the IMSIC's MSI write responder, for devices that bypass the APLIC.
- Single outstanding write, round-robin arbitration, per-source pending latch, bounded retry on error response.

Parameters:
- NR_SRC, 32, number of wired input sources (1..64).
- NR_HARTS, 4, number of addressable IMSICs.
- EIID_W, 6, width of the interrupt identity field; matches $clog2 of the IMSIC source count.
- IMSIC_BASE, 32'h2400_0000, address of the IMSIC 0 interrupt file.
- IMSIC_STRIDE, 32'h0000_1000, address stride between IMSICs.
- MAX_RETRY, 2, resend attempts after an error response before the write is dropped.
- TIMEOUT_CYC, 256, response timeout in cycles (only used under the optional feature).

Ports:
- i_clk, input, 1, clock.
- i_rst, input, 1, synchronous active-high reset.
- i_sources, input, NR_SRC, wired interrupt lines, synchronous to i_clk.
- i_src_en, input, NR_SRC, per-source enable.
- i_target_hart, input, NR_SRC x $clog2(NR_HARTS), destination IMSIC index per source.
- i_eiid, input, NR_SRC x EIID_W, identity written per source.
- o_wr_valid, output, 1, write request valid.
- i_wr_ready, input, 1, write request accepted.
- o_wr_addr, output, 32, MSI target address.
- o_wr_data, output, 32, MSI data.
- i_rsp_valid, input, 1, write response valid.
- i_rsp_err, input, 1, error flag, qualified by i_rsp_valid.
- o_pending, output, NR_SRC, pending latch state.
- o_err_sticky, output, 1, a write was dropped; cleared only by reset.
- o_busy, output, 1, FSM not in IDLE.

Behaviour:
- Reset:
  - Clock and reset are fixed: one clock i_clk; reset i_rst is synchronous, active-high.
  - All outputs are 0 after reset. pending=0, FSM=IDLE, RR pointer=0, retry count=0, prev_src=0.
  - Assertion mid-transaction abandons the write. A late response after reset is ignored.
- Edge detect:
  - edge[i] = i_sources[i] & ~prev_src[i].
  - A rising edge sets pending[i] only when i_src_en[i]=1. Edges on disabled sources are discarded.
  - Further edges while pending[i]=1 coalesce into one MSI.
- Arbitration:
  - In IDLE, the eligible set is pending & i_src_en.
  - Pick the first eligible index at or after the RR pointer, wrapping NR_SRC-1 to 0.
  - Latch the index, addr and data. The RR pointer advances to index+1 (mod NR_SRC).
- Write formation:
  - addr = IMSIC_BASE + i_target_hart*IMSIC_STRIDE, 32-bit, overflow wraps.
  - data = zero-extended eiid.
  - If eiid==0: clear pending with no write issued, return to IDLE, do not set o_err_sticky.
  - An out-of-range hart index is sent as computed.
- FSM:
  - IDLE -> REQ when there is an eligible source with a nonzero eiid. o_wr_valid=1 from the cycle after selection.
  - REQ: hold addr and data stable while valid && !ready. On valid && ready, clear pending[sel] in that cycle and go to RESP.
  - RESP:
    - i_rsp_valid && !i_rsp_err -> IDLE, retry count=0.
    - i_rsp_valid && i_rsp_err && retry count<MAX_RETRY -> REQ, retry count+1, same addr and data.
    - Error with retry count==MAX_RETRY -> set o_err_sticky, go to IDLE.
- Pending clear vs new edge: an edge in the same cycle as the clear keeps pending[sel]=1. A new MSI follows.
- Disable while in flight: if i_src_en[sel] deasserts during REQ or RESP, the transaction still completes.
- Throughput: at most one MSI every 3 cycles with ready and response each returned in the next cycle.
- o_busy = (FSM != IDLE).

Optional Feature:
- Macro MSI_GEN_TIMEOUT_EN.
- Defined:
  - A counter runs in RESP. Reaching TIMEOUT_CYC without i_rsp_valid counts as an error response and follows the retry path.
  - The counter clears on entering RESP.
- Undefined: RESP waits indefinitely and the counter logic is absent.

Test Plan:
- Single source: reset, then pulse i_sources[3] with i_src_en[3]=1, i_target_hart[3]=2, i_eiid[3]=5, ready and response OK. Expect one write, addr=32'h2400_2000, data=32'h5. pending[3] rises then clears on the handshake. o_busy returns to 0.
- Round-robin: sources 0, 1 and 31 pending at once. Expect writes in order 0, 1, 31. Raise source 0 again during the write to 31: 0 is served next.
- Coalescing: 3 edges on source 7 while its write is stalled with i_wr_ready=0 for 10 cycles.
  - Edges before the handshake produce one MSI.
  - An edge coincident with the handshake produces exactly 2 MSIs total.
- Retry: i_rsp_err=1 on every response with MAX_RETRY=2. Expect 3 identical writes, then o_err_sticky=1 and pending cleared.
- eiid=0 source: edge yields no o_wr_valid, pending clears, o_err_sticky stays 0.
- With MSI_GEN_TIMEOUT_EN and TIMEOUT_CYC=16, withhold responses. Expect a resend every 16 cycles after acceptance, 3 writes total, then o_err_sticky=1. Assert i_rst mid-RESP: all outputs 0 on the next cycle.

Source files
------------

// File: rtl/msi_gen_if.sv
// MSI write channel: a posted 32-bit write request plus its single-beat response.
// msi_gen drives the master side; the bus/IMSIC responder sits on the slave side.
interface msi_gen_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        rsp_valid;
    logic        rsp_err;

    modport master (
        output wr_valid, wr_addr, wr_data,
        input  wr_ready, rsp_valid, rsp_err
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        output wr_ready, rsp_valid, rsp_err
    );
endinterface

// File: rtl/msi_gen.sv
// MSI initiator: rising edges on wired interrupt lines become seteipnum_le writes to an IMSIC.
// Optional response timeout enabled by defining MSI_GEN_TIMEOUT_EN.
module msi_gen #(
    parameter int unsigned NR_SRC       = 32,
    parameter int unsigned NR_HARTS     = 4,
    parameter int unsigned EIID_W       = 6,
    parameter logic [31:0] IMSIC_BASE   = 32'h2400_0000,
    parameter logic [31:0] IMSIC_STRIDE = 32'h0000_1000,
    parameter int unsigned MAX_RETRY    = 2,
    parameter int unsigned TIMEOUT_CYC  = 256,
    localparam int unsigned HART_W      = (NR_HARTS > 1) ? $clog2(NR_HARTS) : 1
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [NR_SRC-1:0]               i_sources,
    input  logic [NR_SRC-1:0]               i_src_en,
    input  logic [NR_SRC-1:0][HART_W-1:0]   i_target_hart,
    input  logic [NR_SRC-1:0][EIID_W-1:0]   i_eiid,
    msi_gen_if.master                       bus,
    output logic [NR_SRC-1:0]               o_pending,
    output logic                            o_err_sticky,
    output logic                            o_busy
);

    localparam int unsigned SRC_W = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;
    localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [SRC_W:0]   NR_SRC_X = (SRC_W + 1)'(NR_SRC);
    localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NR_SRC - 1);
    localparam logic [RTY_W-1:0] MAX_RTY  = RTY_W'(MAX_RETRY);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP
    } state_e;

    state_e              state_q,   state_d;
    logic [NR_SRC-1:0]   prev_src_q, prev_src_d;
    logic [NR_SRC-1:0]   pending_q, pending_d;
    logic [SRC_W-1:0]    sel_q,     sel_d;
    logic [SRC_W-1:0]    rr_q,      rr_d;
    logic [31:0]         addr_q,    addr_d;
    logic [31:0]         data_q,    data_d;
    logic [RTY_W-1:0]    retry_q,   retry_d;
    logic                sticky_q,  sticky_d;

    logic [NR_SRC-1:0]   src_edge;
    logic [NR_SRC-1:0]   eligible;
    logic [NR_SRC-1:0]   clr_mask;
    logic                found;
    logic [SRC_W-1:0]    cand;
    logic [SRC_W-1:0]    cand_next;
    logic [SRC_W:0]      scan;
    logic                tmo_fire;
    logic                rsp_ok;
    logic                rsp_fail;

    //------------------------------------------------------------------
    // Edge detect and round-robin pick
    //------------------------------------------------------------------
    assign src_edge   = i_sources & ~prev_src_q;
    assign prev_src_d = i_sources;
    assign eligible   = pending_q & i_src_en;

    // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        found = 1'b0;
        cand  = '0;
        scan  = '0;
        for (int k = 0; k < NR_SRC; k++) begin
            scan = {1'b0, rr_q} + (SRC_W + 1)'(k);
            if (scan >= NR_SRC_X) begin
                scan = scan - NR_SRC_X;
            end
            if (!found && eligible[scan[SRC_W-1:0]]) begin
                found = 1'b1;
                cand  = scan[SRC_W-1:0];
            end
        end
    end

    assign cand_next = (cand == LAST_SRC) ? '0 : cand + SRC_W'(1);

    //------------------------------------------------------------------
    // Response timeout
    //------------------------------------------------------------------
`ifdef MSI_GEN_TIMEOUT_EN
    localparam int unsigned      TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Held at zero outside RESP, so each RESP visit starts a fresh count.
    always_comb begin
        tmo_d = '0;
        if (state_q == ST_RESP) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    assign tmo_fire = (state_q == ST_RESP) && !bus.rsp_valid && (tmo_q == TMO_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    localparam int unsigned UNUSED_TIMEOUT_CYC = TIMEOUT_CYC;
    assign tmo_fire = 1'b0;
`endif

    assign rsp_ok   = bus.rsp_valid && !bus.rsp_err;
    assign rsp_fail = (bus.rsp_valid && bus.rsp_err) || tmo_fire;

    //------------------------------------------------------------------
    // Transaction FSM
    //------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_d     = rr_q;
        addr_d   = addr_q;
        data_d   = data_q;
        retry_d  = retry_q;
        sticky_d = sticky_q;
        clr_mask = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    sel_d = cand;
                    rr_d  = cand_next;
                    if (i_eiid[cand] == '0) begin
                        clr_mask[cand] = 1'b1;
                    end else begin
                        addr_d  = IMSIC_BASE + 32'(i_target_hart[cand]) * IMSIC_STRIDE;
                        data_d  = 32'(i_eiid[cand]);
                        retry_d = '0;
                        state_d = ST_REQ;
                    end
                end
            end

            ST_REQ: begin
                if (bus.wr_ready) begin
                    // Only the first acceptance consumes the latch; an edge seen
                    // while a resend is in flight must still produce its own MSI.
                    if (retry_q == '0) begin
                        clr_mask[sel_q] = 1'b1;
                    end
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                if (rsp_fail) begin
                    if (retry_q < MAX_RTY) begin
                        retry_d = retry_q + RTY_W'(1);
                        state_d = ST_REQ;
                    end else begin
                        sticky_d = 1'b1;
                        retry_d  = '0;
                        state_d  = ST_IDLE;
                    end
                end else if (rsp_ok) begin
                    retry_d = '0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A new edge in the same cycle as the clear wins, so the source is served again.
    assign pending_d = (pending_q & ~clr_mask) | (src_edge & i_src_en);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            prev_src_q <= '0;
            pending_q  <= '0;
            sel_q      <= '0;
            rr_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            retry_q    <= '0;
            sticky_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_src_q <= prev_src_d;
            pending_q  <= pending_d;
            sel_q      <= sel_d;
            rr_q       <= rr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            retry_q    <= retry_d;
            sticky_q   <= sticky_d;
        end
    end

    assign bus.wr_valid = (state_q == ST_REQ);
    assign bus.wr_addr  = addr_q;
    assign bus.wr_data  = data_q;
    assign o_pending    = pending_q;
    assign o_err_sticky = sticky_q;
    assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_msi_gen.sv
// Scoreboard bench for msi_gen: stimulus pushes expected writes, a monitor pops and compares
// on every accepted write, and a responder model answers each accepted write.
`timescale 1ns/1ps
module tb_msi_gen;

    localparam int NR_SRC = 32;
    localparam int HART_W = 2;
    localparam int EIID_W = 6;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NR_SRC-1:0]             sources;
    logic [NR_SRC-1:0]             src_en;
    logic [NR_SRC-1:0][HART_W-1:0] target_hart;
    logic [NR_SRC-1:0][EIID_W-1:0] eiid;
    logic [NR_SRC-1:0]             pending;
    logic                          err_sticky;
    logic                          busy;

    msi_gen_if bus ();

    msi_gen #(
        .NR_SRC       (NR_SRC),
        .NR_HARTS     (4),
        .EIID_W       (EIID_W),
        .IMSIC_BASE   (32'h2400_0000),
        .IMSIC_STRIDE (32'h0000_1000),
        .MAX_RETRY    (2),
        .TIMEOUT_CYC  (16)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_sources     (sources),
        .i_src_en      (src_en),
        .i_target_hart (target_hart),
        .i_eiid        (eiid),
        .bus           (bus),
        .o_pending     (pending),
        .o_err_sticky  (err_sticky),
        .o_busy        (busy)
    );

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_writes = 0;
    int  n_valid_cyc = 0;
    int  cyc = 0;

    bit  err_mode = 1'b0;
    bit  rsp_hold = 1'b0;
    bit  late_rsp = 1'b0;
    bit  tmo_mode = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name, input int waited);
        n_checks++;
        n_fail++;
        $display("FAIL %s: condition not reached after %0d cycles", name, waited);
    endtask

    always @(posedge clk) cyc++;

    //------------------------------------------------------------------
    // Monitor / scoreboard
    //------------------------------------------------------------------
    bit          stalled = 1'b0;
    logic [31:0] hold_addr, hold_data;
    wr_t         got;
    int          last_hs_cyc = 0;
    int          tmo_hs_n = 0;

    always @(negedge clk) begin
        if (bus.wr_valid) begin
            n_valid_cyc++;
            if (stalled) begin
                check("stall_addr_stable", bus.wr_addr, hold_addr);
                check("stall_data_stable", bus.wr_data, hold_data);
            end
            if (bus.wr_ready) begin
                stalled = 1'b0;
                n_writes++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr=%h data=%h with empty scoreboard",
                             bus.wr_addr, bus.wr_data);
                end else begin
                    got = exp_q.pop_front();
                    check("wr_addr", bus.wr_addr, got.addr);
                    check("wr_data", bus.wr_data, got.data);
                end
                if (tmo_mode) begin
                    if (tmo_hs_n > 0) check("tmo_resend_gap", cyc - last_hs_cyc, 17);
                    tmo_hs_n++;
                end
                last_hs_cyc = cyc;
            end else begin
                stalled   = 1'b1;
                hold_addr = bus.wr_addr;
                hold_data = bus.wr_data;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    //------------------------------------------------------------------
    // Responder: answers each accepted write in the following cycle
    //------------------------------------------------------------------
    initial begin
        int seen_writes;
        seen_writes   = 0;
        bus.rsp_valid = 1'b0;
        bus.rsp_err   = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.rsp_valid = ((n_writes != seen_writes) && !rsp_hold) || late_rsp;
            bus.rsp_err   = err_mode;
            seen_writes   = n_writes;
        end
    end

    //------------------------------------------------------------------
    // Stimulus
    //------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic pulse(input int idx);
        sources[idx] = 1'b1;
        tick(1);
        sources[idx] = 1'b0;
    endtask

    task automatic expect_wr(input logic [31:0] addr, input logic [31:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic wait_quiet(input string name, input int max_cyc);
        int n;
        n = 0;
        while ((busy || pending != '0 || exp_q.size() != 0) && n < max_cyc) begin
            tick(1);
            n++;
        end
        if (n >= max_cyc) timeout_fail(name, n);
    endtask

    bit hit;
    int w0;
    int v0;

    initial begin
        rst         = 1'b1;
        sources     = '0;
        src_en      = '1;
        target_hart = '0;
        for (int i = 0; i < NR_SRC; i++) eiid[i] = EIID_W'(i + 1);
        bus.wr_ready = 1'b1;

        // Reset state
        tick(3);
        check("rst_wr_valid", bus.wr_valid, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_pending", pending, 0);
        check("rst_err_sticky", err_sticky, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick(1);

        // Single source: hart 2, eiid 5
        eiid[3]        = 6'd5;
        target_hart[3] = 2'd2;
        w0 = n_writes;
        expect_wr(32'h2400_2000, 32'h0000_0005);
        pulse(3);
        check("single_pending_set", pending[3], 1);
        wait_quiet("single_quiet", 20);
        check("single_pending_clr", pending, 0);
        check("single_busy_clr", busy, 0);
        check("single_write_count", n_writes - w0, 1);

        // Round-robin: 0, 1, 31, then 0 again raised during the write to 31
        do_reset();
        eiid[0] = 6'd1;  target_hart[0]  = 2'd0;
        eiid[1] = 6'd2;  target_hart[1]  = 2'd1;
        eiid[31] = 6'd32; target_hart[31] = 2'd3;
        w0 = n_writes;
        expect_wr(32'h2400_0000, 32'h1);
        expect_wr(32'h2400_1000, 32'h2);
        expect_wr(32'h2400_3000, 32'h20);
        sources[0] = 1'b1; sources[1] = 1'b1; sources[31] = 1'b1;
        tick(1);
        sources = '0;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (bus.wr_valid && bus.wr_addr == 32'h2400_3000) hit = 1'b1;
            else tick(1);
        end
        if (!hit) timeout_fail("rr_wait_src31", 40);
        expect_wr(32'h2400_0000, 32'h1);
        pulse(0);
        wait_quiet("rr_quiet", 40);
        check("rr_write_count", n_writes - w0, 4);

        // Coalescing: three edges during a 10-cycle stall yield one MSI
        do_reset();
        eiid[7] = 6'd7; target_hart[7] = 2'd3;
        w0 = n_writes;
        bus.wr_ready = 1'b0;
        expect_wr(32'h2400_3000, 32'h7);
        pulse(7);
        tick(1);
        pulse(7);
        tick(1);
        pulse(7);
        tick(5);
        check("coal_stalled_valid", bus.wr_valid, 1);
        bus.wr_ready = 1'b1;
        wait_quiet("coal_quiet", 20);
        check("coal_write_count", n_writes - w0, 1);

        // Edge coincident with the handshake keeps pending: two MSIs total
        w0 = n_writes;
        bus.wr_ready = 1'b0;
        expect_wr(32'h2400_3000, 32'h7);
        expect_wr(32'h2400_3000, 32'h7);
        pulse(7);
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            if (bus.wr_valid) hit = 1'b1;
            else tick(1);
        end
        if (!hit) timeout_fail("coal2_wait_valid", 10);
        tick(2);
        bus.wr_ready = 1'b1;
        sources[7]   = 1'b1;
        tick(1);
        sources[7] = 1'b0;
        check("coal2_pending_kept", pending[7], 1);
        wait_quiet("coal2_quiet", 20);
        check("coal2_write_count", n_writes - w0, 2);

        // Retry: every response is an error, three identical writes then drop
        do_reset();
        err_mode = 1'b1;
        eiid[5] = 6'd9; target_hart[5] = 2'd1;
        w0 = n_writes;
        repeat (3) expect_wr(32'h2400_1000, 32'h9);
        pulse(5);
        check("retry_sticky_before", err_sticky, 0);
        wait_quiet("retry_quiet", 40);
        check("retry_sticky_set", err_sticky, 1);
        check("retry_pending_clr", pending, 0);
        check("retry_write_count", n_writes - w0, 3);
        err_mode = 1'b0;

        // eiid == 0: pending drops with no write and no sticky error
        do_reset();
        check("eiid0_sticky_after_rst", err_sticky, 0);
        eiid[9] = 6'd0;
        v0 = n_valid_cyc;
        pulse(9);
        check("eiid0_pending_set", pending[9], 1);
        tick(1);
        check("eiid0_pending_clr", pending, 0);
        check("eiid0_busy", busy, 0);
        tick(3);
        check("eiid0_no_valid", n_valid_cyc - v0, 0);
        check("eiid0_sticky", err_sticky, 0);

`ifdef MSI_GEN_TIMEOUT_EN
        // Withheld responses: resend 16 cycles after each acceptance, then drop
        do_reset();
        rsp_hold = 1'b1;
        tmo_mode = 1'b1;
        eiid[4] = 6'd17; target_hart[4] = 2'd2;
        w0 = n_writes;
        repeat (3) expect_wr(32'h2400_2000, 32'h11);
        pulse(4);
        wait_quiet("tmo_quiet", 120);
        check("tmo_sticky_set", err_sticky, 1);
        check("tmo_write_count", n_writes - w0, 3);
        tmo_mode = 1'b0;
        rsp_hold = 1'b0;
`endif

        // Reset in RESP abandons the write; a late response is ignored
        do_reset();
        rsp_hold = 1'b1;
        eiid[2] = 6'd3; target_hart[2] = 2'd0;
        expect_wr(32'h2400_0000, 32'h3);
        pulse(2);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (exp_q.size() == 0 && busy && !bus.wr_valid) hit = 1'b1;
            else tick(1);
        end
        if (!hit) timeout_fail("mid_wait_resp", 20);
        tick(3);
        check("mid_busy_in_resp", busy, 1);
        rst = 1'b1;
        tick(1);
        check("mid_rst_wr_valid", bus.wr_valid, 0);
        check("mid_rst_wr_addr", bus.wr_addr, 0);
        check("mid_rst_wr_data", bus.wr_data, 0);
        check("mid_rst_pending", pending, 0);
        check("mid_rst_sticky", err_sticky, 0);
        check("mid_rst_busy", busy, 0);
        rst      = 1'b0;
        rsp_hold = 1'b0;
        late_rsp = 1'b1;
        tick(1);
        late_rsp = 1'b0;
        tick(2);
        check("late_rsp_busy", busy, 0);
        check("late_rsp_valid", bus.wr_valid, 0);
        check("late_rsp_sticky", err_sticky, 0);
        check("late_rsp_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
